// File: rtl/mod2_dsm_mc.sv
// mod2_dsm_mc -- multi-channel 2nd-order delta-sigma modulator.
//
// PCM frames (NUM_CH signed samples) arrive over a valid/ready handshake into
// a one-deep "next" buffer. Every OSR enabled ticks the next frame becomes
// the active frame that feeds the modulators. Each channel runs two
// saturating integrators and produces a 1-bit stream from the sign of the
// second integrator.
//
// Optional feature: define DSM_DITHER_EN to add a per-channel 16-bit LFSR
// whose LSB is injected into the second integrator. Without it the
// modulator is fully deterministic.
//
// Ports
//   clk            modulator clock
//   rst            synchronous active-high reset
//   en             tick enable; low freezes counter, integrators and frames
//   in_data        frame, channel k at [k*DATA_WIDTH +: DATA_WIDTH], signed
//   in_valid       frame valid
//   in_ready       next-frame buffer empty
//   out_bitstream  1-bit output stream per channel
//   frame_tick     pulse in the cycle the active frame is swapped
//   underrun       sticky: frame boundary reached with no buffered frame
//   overload       sticky per channel: an integrator saturated
//   clr_status     clears underrun/overload (a same-cycle set wins)
module mod2_dsm_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int OSR        = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NUM_CH-1:0]            out_bitstream,
  output logic                         frame_tick,
  output logic                         underrun,
  output logic [NUM_CH-1:0]            overload,
  input  logic                         clr_status
);

  localparam int INT_WIDTH = DATA_WIDTH + 3;
  localparam int SUM_WIDTH = INT_WIDTH + 2;
  localparam int CNT_WIDTH = (OSR > 1) ? $clog2(OSR) : 1;

  localparam int FB_I      = 2 ** (DATA_WIDTH - 1);
  localparam int INT_MAX_I = 2 ** (INT_WIDTH - 1) - 1;
  localparam int INT_MIN_I = -(2 ** (INT_WIDTH - 1));

  localparam logic signed [SUM_WIDTH-1:0] FB      = FB_I[SUM_WIDTH-1:0];
  localparam logic signed [SUM_WIDTH-1:0] INT_MAX = INT_MAX_I[SUM_WIDTH-1:0];
  localparam logic signed [SUM_WIDTH-1:0] INT_MIN = INT_MIN_I[SUM_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0]        CNT_LAST = CNT_WIDTH'(OSR - 1);

  logic [CNT_WIDTH-1:0]          osr_cnt;
  logic [NUM_CH*DATA_WIDTH-1:0]  active_q;
  logic [NUM_CH*DATA_WIDTH-1:0]  next_q;
  logic                          next_full;
  logic signed [INT_WIDTH-1:0]   i1_q [NUM_CH];
  logic signed [INT_WIDTH-1:0]   i2_q [NUM_CH];
  logic signed [INT_WIDTH-1:0]   i1_d [NUM_CH];
  logic signed [INT_WIDTH-1:0]   i2_d [NUM_CH];
  logic [NUM_CH-1:0]             clip;
  logic signed [SUM_WIDTH-1:0]   dith [NUM_CH];

  logic accept;
  logic boundary;

  assign in_ready   = ~next_full & ~rst;
  assign accept     = in_valid & in_ready;
  assign boundary   = en & (osr_cnt == CNT_LAST);
  assign frame_tick = boundary & ~rst;

  function automatic logic signed [INT_WIDTH-1:0] clamp(input logic signed [SUM_WIDTH-1:0] v);
    if (v > INT_MAX)      return INT_MAX[INT_WIDTH-1:0];
    else if (v < INT_MIN) return INT_MIN[INT_WIDTH-1:0];
    else                  return v[INT_WIDTH-1:0];
  endfunction

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr_q [NUM_CH];

  // Fibonacci LFSR, taps 16,14,13,11; each channel gets a distinct seed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst)     lfsr_q[k] <= 16'hACE1 ^ 16'(k);
      else if (en) lfsr_q[k] <= {lfsr_q[k][14:0],
                                 lfsr_q[k][15] ^ lfsr_q[k][13] ^ lfsr_q[k][12] ^ lfsr_q[k][10]};
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      dith[k] = {{(SUM_WIDTH-1){1'b0}}, lfsr_q[k][0]};
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      dith[k] = '0;
  end
`endif

  // Integrator update. Sums use two guard bits so clamping sees the true
  // value; the state therefore saturates and never wraps.
  always_comb begin
    logic signed [SUM_WIDTH-1:0] x_ext;
    logic signed [SUM_WIDTH-1:0] fb;
    logic signed [SUM_WIDTH-1:0] s1;
    logic signed [SUM_WIDTH-1:0] s2;
    // NOTE: everything this block writes gets a default first, so no path
    // can leave a value unassigned and infer a latch.
    clip  = '0;
    x_ext = '0;
    fb    = '0;
    s1    = '0;
    s2    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      i1_d[k] = i1_q[k];
      i2_d[k] = i2_q[k];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      x_ext   = SUM_WIDTH'($signed(active_q[k*DATA_WIDTH +: DATA_WIDTH]));
      fb      = i2_q[k][INT_WIDTH-1] ? -FB : FB;
      s1      = SUM_WIDTH'(i1_q[k]) + x_ext - fb;
      s2      = SUM_WIDTH'(i2_q[k]) + SUM_WIDTH'(i1_q[k]) + dith[k] - (fb <<< 1);
      i1_d[k] = clamp(s1);
      i2_d[k] = clamp(s2);
      clip[k] = (s1 > INT_MAX) | (s1 < INT_MIN) | (s2 > INT_MAX) | (s2 < INT_MIN);
    end
  end

  // Output is the inverted sign of the registered second integrator.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      out_bitstream[k] = ~i2_q[k][INT_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      osr_cnt   <= '0;
      active_q  <= '0;
      next_q    <= '0;
      next_full <= 1'b0;
      underrun  <= 1'b0;
      overload  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        i1_q[k] <= '0;
        i2_q[k] <= '0;
      end
    end else begin
      // The handshake is independent of en; accept and swap are mutually
      // exclusive because accept needs an empty next buffer.
      if (accept) begin
        next_q    <= in_data;
        next_full <= 1'b1;
      end
      if (en) begin
        for (int k = 0; k < NUM_CH; k++) begin
          i1_q[k] <= i1_d[k];
          i2_q[k] <= i2_d[k];
        end
        osr_cnt <= boundary ? '0 : osr_cnt + 1'b1;
        if (boundary && next_full) begin
          active_q  <= next_q;
          next_full <= 1'b0;
        end
      end
      underrun <= (underrun & ~clr_status) | (boundary & ~next_full);
      overload <= (overload & ~{NUM_CH{clr_status}}) | (en ? clip : '0);
    end
  end

endmodule

// File: tb/tb_mod2_dsm_mc.sv
// Testbench for mod2_dsm_mc (default build, no dither). A cycle-level
// reference model written with plain integer arithmetic predicts every
// output each cycle; directed phases add aggregate checks on ones density,
// underrun and overload behaviour.
module tb_mod2_dsm_mc;

  localparam int DW   = 16;
  localparam int NCH  = 2;
  localparam int OSR  = 64;
  localparam int IW   = DW + 3;
  localparam int FB   = 1 << (DW - 1);
  localparam int IMAX = (1 << (IW - 1)) - 1;
  localparam int IMIN = -(1 << (IW - 1));

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [NCH*DW-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [NCH-1:0]      out_bitstream;
  logic                frame_tick;
  logic                underrun;
  logic [NCH-1:0]      overload;
  logic                clr_status;

  mod2_dsm_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .OSR(OSR)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_bitstream (out_bitstream),
    .frame_tick    (frame_tick),
    .underrun      (underrun),
    .overload      (overload),
    .clr_status    (clr_status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain integers and flags.
  int           m_i1  [NCH];
  int           m_i2  [NCH];
  int           m_act [NCH];
  int           m_nxt [NCH];
  bit           m_full;
  bit           m_under;
  bit [NCH-1:0] m_ovl;
  int           m_cnt;
  int           ones  [NCH];

  function automatic int sat(input int v, output bit hit);
    hit = (v > IMAX) || (v < IMIN);
    if (v > IMAX) return IMAX;
    if (v < IMIN) return IMIN;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_i1[k] = 0; m_i2[k] = 0; m_act[k] = 0; m_nxt[k] = 0;
    end
    m_full = 0; m_under = 0; m_ovl = '0; m_cnt = 0;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the
  // model with the same inputs, then move to just after the next edge.
  task automatic step(input bit r, input bit e, input bit v, input bit c,
                      input logic [NCH*DW-1:0] d);
    logic [NCH-1:0] exp_out;
    bit             acc, uset, h1, h2;
    bit [NCH-1:0]   oset;
    int             x, fb, n1, n2;
    rst = r; en = e; in_valid = v; clr_status = c; in_data = d;
    #1;
    for (int k = 0; k < NCH; k++) exp_out[k] = (m_i2[k] >= 0);
    cmp("out_bitstream", out_bitstream, exp_out);
    cmp("in_ready",      in_ready,      !r && !m_full);
    cmp("frame_tick",    frame_tick,    !r && e && (m_cnt == OSR - 1));
    cmp("underrun",      underrun,      m_under);
    cmp("overload",      overload,      m_ovl);
    for (int k = 0; k < NCH; k++) if (exp_out[k]) ones[k]++;

    if (r) begin
      model_reset();
    end else begin
      acc  = v && !m_full;
      uset = 0;
      oset = '0;
      if (e) begin
        for (int k = 0; k < NCH; k++) begin
          x  = m_act[k];
          fb = (m_i2[k] >= 0) ? FB : -FB;
          n1 = sat(m_i1[k] + x - fb, h1);
          n2 = sat(m_i2[k] + m_i1[k] - 2 * fb, h2);
          m_i1[k] = n1;
          m_i2[k] = n2;
          oset[k] = h1 | h2;
        end
        if (m_cnt == OSR - 1) begin
          if (m_full) begin
            for (int k = 0; k < NCH; k++) m_act[k] = m_nxt[k];
            m_full = 0;
          end else begin
            uset = 1;
          end
        end
        m_cnt = (m_cnt + 1) % OSR;
      end
      if (acc) begin
        for (int k = 0; k < NCH; k++) m_nxt[k] = int'($signed(d[k*DW +: DW]));
        m_full = 1;
      end
      m_under = (m_under && !c) || uset;
      m_ovl   = (c ? '0 : m_ovl) | oset;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit e, input bit v, input logic [NCH*DW-1:0] d);
    for (int i = 0; i < n; i++) step(1'b0, e, v, 1'b0, d);
  endtask

  task automatic clear_ones();
    for (int k = 0; k < NCH; k++) ones[k] = 0;
  endtask

  function automatic logic [NCH*DW-1:0] frame(input int ch0, input int ch1);
    logic [NCH*DW-1:0] f;
    f = '0;
    f[0 +: DW]  = DW'(ch0);
    f[DW +: DW] = DW'(ch1);
    return f;
  endfunction

  initial begin
    logic [NCH*DW-1:0] d;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; clr_status = 1'b0; in_data = '0;
    clear_ones();
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Zero input from reset: 1,0,0,1 pattern, half density.
    clear_ones();
    run(1024, 1'b1, 1'b1, frame(0, 0));
    for (int k = 0; k < NCH; k++) cmp("ones_zero", ones[k], 512);

    // +FB/2 on both channels: 3/4 density.
    run(3 * OSR, 1'b1, 1'b1, frame(16'h4000, 16'h4000));
    clear_ones();
    run(1024, 1'b1, 1'b1, frame(16'h4000, 16'h4000));
    for (int k = 0; k < NCH; k++) cmp("ones_pos_half", (ones[k] >= 766) && (ones[k] <= 770), 1);

    // -FB/2 on both channels: 1/4 density.
    run(3 * OSR, 1'b1, 1'b1, frame(16'hC000, 16'hC000));
    clear_ones();
    run(1024, 1'b1, 1'b1, frame(16'hC000, 16'hC000));
    for (int k = 0; k < NCH; k++) cmp("ones_neg_half", (ones[k] >= 254) && (ones[k] <= 258), 1);
    cmp("no_ovl_half", overload, '0);

    // One frame only, then starve: underrun after the second frame_tick.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, frame(0, 0));
    run(3 * OSR, 1'b1, 1'b0, '0);
    cmp("underrun_set", underrun, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0);
    cmp("underrun_clr", underrun, 1'b0);

    // Full negative scale on channel 0 after a small offset frame:
    // channel 0 must saturate, channel 1 (zero input) must not.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, frame(-100, 0));
    run(6 * OSR, 1'b1, 1'b1, frame(-32768, 0));
    cmp("ovl_sat", overload, 2'b01);

    // Mid-frame reset, then en low for 10 cycles with the handshake live.
    run(30, 1'b1, 1'b1, frame(1234, -4321));
    step(1'b1, 1'b1, 1'b1, 1'b0, frame(1234, -4321));
    run(45, 1'b1, 1'b1, frame(8000, -9000));
    run(10, 1'b0, 1'b1, frame(8000, -9000));
    run(2 * OSR, 1'b1, 1'b1, frame(8000, -9000));

    // Random traffic: full-range data, sparse valid, en and clr.
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NCH; k++) d[k*DW +: DW] = DW'($urandom);
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
